// File: rtl/vga_timing_generator.sv
// Raster timing source: pixel/line counters with visible flag, syncs and start strobes.
// Every output is decoded from the next-state counters and registered alongside them.
module vga_timing_generator #(
    parameter int H_VISIBLE        = 640,
    parameter int H_FRONT          = 16,
    parameter int H_SYNC           = 96,
    parameter int H_BACK           = 48,
    parameter int V_VISIBLE        = 480,
    parameter int V_FRONT          = 10,
    parameter int V_SYNC           = 2,
    parameter int V_BACK           = 33,
    parameter int HSYNC_ACTIVE_LOW = 1,
    parameter int VSYNC_ACTIVE_LOW = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ce,
    output logic [9:0] o_hpos,
    output logic [9:0] o_vpos,
    output logic       o_visible,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_line_start,
    output logic       o_frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL > 1024) begin : g_bad_htotal
        $error("vga_timing_generator: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > 1024) begin : g_bad_vtotal
        $error("vga_timing_generator: V_TOTAL exceeds 1024");
    end
    if (H_BACK < 1 || V_BACK < 1) begin : g_bad_back
        $error("vga_timing_generator: back porches must be at least 1");
    end

    // A non-zero back porch keeps the sync end strictly below TOTAL, so 10 bits suffice.
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic       HS_ON    = (HSYNC_ACTIVE_LOW == 0);
    localparam logic       VS_ON    = (VSYNC_ACTIVE_LOW == 0);

    logic [9:0] hpos_q, hpos_d;
    logic [9:0] vpos_q, vpos_d;
    logic       visible_q, visible_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;

    always_comb begin
        hpos_d = hpos_q + 10'd1;
        vpos_d = vpos_q;
        if (hpos_q == H_LAST) begin
            hpos_d = '0;
            if (vpos_q == V_LAST) begin
                vpos_d = '0;
            end else begin
                vpos_d = vpos_q + 10'd1;
            end
        end

        visible_d     = (hpos_d < H_VIS) && (vpos_d < V_VIS);
        hsync_d       = ((hpos_d >= HS_START) && (hpos_d < HS_END)) ? HS_ON : ~HS_ON;
        vsync_d       = ((vpos_d >= VS_START) && (vpos_d < VS_END)) ? VS_ON : ~VS_ON;
        line_start_d  = (hpos_d == '0);
        frame_start_d = (hpos_d == '0) && (vpos_d == '0);
    end

    // Reset parks the raster on the last pixel so the first enabled edge lands on (0,0).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hpos_q        <= H_LAST;
            vpos_q        <= V_LAST;
            visible_q     <= 1'b0;
            hsync_q       <= ~HS_ON;
            vsync_q       <= ~VS_ON;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (i_ce) begin
            hpos_q        <= hpos_d;
            vpos_q        <= vpos_d;
            visible_q     <= visible_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign o_hpos        = hpos_q;
    assign o_vpos        = vpos_q;
    assign o_visible     = visible_q;
    assign o_hsync       = hsync_q;
    assign o_vsync       = vsync_q;
    assign o_line_start  = line_start_q;
    assign o_frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: default 640x480 instance plus a tiny 8x6 instance,
// both tracked by a linear pixel-index reference model.
module tb_vga_timing_generator;

    localparam int A_HT = 800;
    localparam int A_VT = 525;
    localparam int B_HT = 8;
    localparam int B_VT = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ce_a = 1'b1;
    logic       ce_b = 1'b1;

    logic [9:0] a_hpos, a_vpos, b_hpos, b_vpos;
    logic       a_vis, a_hs, a_vs, a_ls, a_fs;
    logic       b_vis, b_hs, b_vs, b_ls, b_fs;
    logic [24:0] a_vec, b_vec;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_timing_generator u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce_a),
        .o_hpos(a_hpos), .o_vpos(a_vpos), .o_visible(a_vis),
        .o_hsync(a_hs), .o_vsync(a_vs),
        .o_line_start(a_ls), .o_frame_start(a_fs)
    );

    vga_timing_generator #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_ACTIVE_LOW(1), .VSYNC_ACTIVE_LOW(1)
    ) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce_b),
        .o_hpos(b_hpos), .o_vpos(b_vpos), .o_visible(b_vis),
        .o_hsync(b_hs), .o_vsync(b_vs),
        .o_line_start(b_ls), .o_frame_start(b_fs)
    );

    assign a_vec = {a_hpos, a_vpos, a_vis, a_hs, a_vs, a_ls, a_fs};
    assign b_vec = {b_hpos, b_vpos, b_vis, b_hs, b_vs, b_ls, b_fs};

    // Reference model: linear position within the frame; reset sits on the last pixel.
    int na, nb;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            na <= A_HT * A_VT - 1;
            nb <= B_HT * B_VT - 1;
        end else begin
            if (ce_a) na <= (na + 1) % (A_HT * A_VT);
            if (ce_b) nb <= (nb + 1) % (B_HT * B_VT);
        end
    end

    function automatic logic [24:0] model_vec(int n, int ht, int hvis, int hfp, int hsw,
                                              int vvis, int vfp, int vsw);
        int h = n % ht;
        int v = n / ht;
        logic vis = (h < hvis) && (v < vvis);
        logic hs  = !((h >= hvis + hfp) && (h < hvis + hfp + hsw));
        logic vs  = !((v >= vvis + vfp) && (v < vvis + vfp + vsw));
        logic ls  = (h == 0);
        logic fs  = (h == 0) && (v == 0);
        return {10'(h), 10'(v), vis, hs, vs, ls, fs};
    endfunction

    task automatic cmp(input string name, input logic [24:0] act, input logic [24:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got h=%0d v=%0d vis/hs/vs/ls/fs=%b, expected h=%0d v=%0d vis/hs/vs/ls/fs=%b",
                     name, act[24:15], act[14:5], act[4:0], exp[24:15], exp[14:5], exp[4:0]);
        end
    endtask

    task automatic cmp_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for raster position", name);
    endtask

    task automatic check_models();
        cmp("model_a", a_vec, model_vec(na, A_HT, 640, 16, 96, 480, 10, 2));
        cmp("model_b", b_vec, model_vec(nb, B_HT, 4, 1, 2, 3, 1, 1));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check_models();
    endtask

    typedef struct {
        logic       ce;
        int         h;
        int         v;
        logic [4:0] flags;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int bound;
        int first_low, last_low, low_cnt;
        int prev_fs, period, vlow, frames;
        logic [24:0] v;

        tbl[0] = '{1'b1, 0, 0, 5'b11111};
        tbl[1] = '{1'b1, 1, 0, 5'b11100};
        tbl[2] = '{1'b0, 1, 0, 5'b11100};
        tbl[3] = '{1'b1, 2, 0, 5'b11100};
        tbl[4] = '{1'b1, 3, 0, 5'b11100};
        tbl[5] = '{1'b1, 4, 0, 5'b01100};
        tbl[6] = '{1'b1, 5, 0, 5'b00100};
        tbl[7] = '{1'b1, 6, 0, 5'b00100};
        tbl[8] = '{1'b1, 7, 0, 5'b01100};
        tbl[9] = '{1'b1, 0, 1, 5'b11110};

        // Reset state
        repeat (3) @(negedge clk);
        cmp("reset_a", a_vec, {10'd799, 10'd524, 5'b01100});
        cmp("reset_b", b_vec, {10'd7, 10'd5, 5'b01100});
        check_models();

        // Release, then table-driven walk on the tiny instance
        rst_n = 1'b1;
        ce_a  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ce_b = tbl[i].ce;
            tick();
            v = {10'(tbl[i].h), 10'(tbl[i].v), tbl[i].flags};
            cmp($sformatf("tiny_vec%0d", i), b_vec, v);
            if (i == 0) cmp("first_edge_a", a_vec, {10'd0, 10'd0, 5'b11111});
            if (i == 1) cmp("second_edge_a", a_vec, {10'd1, 10'd0, 5'b11100});
        end
        ce_b = 1'b1;

        // Horizontal boundaries on line 0
        bound = 0;
        while (!(a_hpos == 10'd639 && a_vpos == 10'd0) && bound < 2000) begin tick(); bound++; end
        if (bound >= 2000) timeout_fail("reach_639");
        cmp("hpos639_a", a_vec, {10'd639, 10'd0, 5'b11100});
        tick();
        cmp("hpos640_a", a_vec, {10'd640, 10'd0, 5'b01100});
        first_low = -1; last_low = -1; low_cnt = 0;
        bound = 0;
        while (!(a_hpos == 10'd799) && bound < 2000) begin
            tick();
            bound++;
            if (!a_hs) begin
                if (first_low < 0) first_low = int'(a_hpos);
                last_low = int'(a_hpos);
                low_cnt++;
            end
        end
        if (bound >= 2000) timeout_fail("reach_799");
        cmp_int("hsync_first_low", first_low, 656);
        cmp_int("hsync_last_low", last_low, 751);
        cmp_int("hsync_low_count", low_cnt, 96);
        tick();
        cmp("line_wrap_a", a_vec, {10'd0, 10'd1, 5'b11110});

        // Clock-enable hold mid-line
        bound = 0;
        while (!(a_hpos == 10'd100 && a_vpos == 10'd10) && bound < 20000) begin tick(); bound++; end
        if (bound >= 20000) timeout_fail("reach_100_10");
        ce_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            cmp($sformatf("ce_hold%0d", i), a_vec, {10'd100, 10'd10, 5'b11100});
        end
        ce_a = 1'b1;
        tick();
        cmp("ce_resume", a_vec, {10'd101, 10'd10, 5'b11100});

        // Tiny frame period and vertical sync width with ce held high
        prev_fs = -1; period = 0; vlow = 0; frames = 0;
        bound = 0;
        while (frames < 3 && bound < 400) begin
            tick();
            bound++;
            period++;
            if (b_fs) begin
                if (prev_fs >= 0) begin
                    cmp_int("tiny_frame_period", period, 48);
                    cmp_int("tiny_vsync_low_cycles", vlow, 8);
                    frames++;
                end
                prev_fs = 1; period = 0; vlow = 0;
            end
            if (!b_vs) begin
                vlow++;
                cmp_int("tiny_vsync_line", int'(b_vpos), 4);
            end
        end
        if (frames < 3) timeout_fail("tiny_frames");

        // Random enables against the model
        for (int i = 0; i < 3000; i++) begin
            ce_a = 1'($urandom_range(0, 1));
            ce_b = 1'($urandom_range(0, 3) != 0);
            tick();
        end
        ce_a = 1'b1;
        ce_b = 1'b1;

        // Asynchronous reset between edges
        bound = 0;
        while (!(a_hpos == 10'd700) && bound < 2000) begin tick(); bound++; end
        if (bound >= 2000) timeout_fail("reach_700");
        #2;
        rst_n = 1'b0;
        #1;
        cmp("async_reset_a", a_vec, {10'd799, 10'd524, 5'b01100});
        cmp("async_reset_b", b_vec, {10'd7, 10'd5, 5'b01100});
        @(negedge clk);
        check_models();
        rst_n = 1'b1;
        tick();
        cmp("reset_recover_a", a_vec, {10'd0, 10'd0, 5'b11111});
        cmp("reset_recover_b", b_vec, {10'd0, 10'd0, 5'b11111});
        for (int i = 0; i < 200; i++) begin
            ce_a = 1'($urandom_range(0, 1));
            ce_b = 1'($urandom_range(0, 1));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_generator.md
Name: vga_timing_generator

Overview:
- Raster timing source feeding the pixel-renderer blocks (digit/bitmap generators) that consume hpos/vpos/visible.
- Produces pixel position counters, the visible-area flag, and HSYNC/VSYNC for 640x480@60 at a 25 MHz pixel rate by default.
- Drives both the renderers and the VGA output pins, so position and sync stay cycle-coherent.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels); must be >= 1
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines); must be >= 1
- HSYNC_ACTIVE_LOW, 1, 1 = o_hsync is low during the sync pulse
- VSYNC_ACTIVE_LOW, 1, 1 = o_vsync is low during the sync pulse

Ports:
- i_clk  input  1  pixel-domain clock
- i_rst_n  input  1  asynchronous active-low reset
- i_ce  input  1  pixel clock enable; tie high for a 25 MHz i_clk
- o_hpos  output  10  current pixel column, 0..H_TOTAL-1
- o_vpos  output  10  current line, 0..V_TOTAL-1
- o_visible  output  1  high when hpos < H_VISIBLE and vpos < V_VISIBLE
- o_hsync  output  1  horizontal sync, polarity per parameter
- o_vsync  output  1  vertical sync, polarity per parameter
- o_line_start  output  1  one-enabled-cycle strobe while hpos==0
- o_frame_start  output  1  one-enabled-cycle strobe while hpos==0 and vpos==0

Behaviour:
- One clock (i_clk); reset is asynchronous, active-low (i_rst_n).
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800). V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525). Both must be <= 1024. Violations are caught by an elaboration-time check.
- All outputs are registered. Every output describes the same pixel as o_hpos/o_vpos in that cycle, with zero skew between outputs.
- Reset values, while i_rst_n is low:
  - o_hpos = H_TOTAL-1, o_vpos = V_TOTAL-1
  - o_visible = 0
  - o_hsync, o_vsync inactive
  - o_line_start = 0, o_frame_start = 0
- Counting: advances only on a rising edge of i_clk with i_ce=1. With i_ce=0, every output holds, including the strobes.
- Horizontal: hpos increments by 1. When hpos==H_TOTAL-1, hpos goes to 0 and vpos advances.
- Vertical: vpos increments by 1 on each horizontal wrap. When vpos==V_TOTAL-1 at the horizontal wrap, vpos goes to 0.
- Reset recovery: the first enabled edge after reset release yields (0,0), o_visible=1, o_line_start=1, o_frame_start=1.
- Horizontal sync: active while H_VISIBLE+H_FRONT <= hpos < H_VISIBLE+H_FRONT+H_SYNC (656..751).
- Vertical sync: active while V_VISIBLE+V_FRONT <= vpos < V_VISIBLE+V_FRONT+V_SYNC (490..491), for whole lines, hpos-independent.
- Strobes: o_line_start and o_frame_start are decoded from the next-state counters and registered with them.
- Asynchronous reset mid-frame immediately forces the reset values; no partial-line state survives.
- Implementation: two counters with next-state comparators. Compare against parameter-derived constants, not hard-coded numbers.

Test Plan:
- Reset then release with i_ce=1 -> during reset (799,524), visible=0, hsync=vsync=1. First edge -> (0,0), visible=1, line_start=1, frame_start=1. Next edge -> (1,0), both strobes 0.
- Horizontal boundaries on line 0 -> visible 1 at hpos 639, 0 at 640. hsync falls at hpos 656, rises at 752 (96 cycles low). At hpos 799 the next edge -> (0,1) with line_start=1, frame_start=0.
- Vertical boundaries -> visible stays 0 for all of vpos 480..524. vsync low exactly for lines 490..491 (1600 enabled cycles). Frame wraps (799,524)->(0,0) with frame_start=1. Frame period is 420000 enabled cycles.
- i_ce toggled 1-0-1 mid-line at (100,10) -> all outputs frozen while i_ce=0; resumes at (101,10) with no skipped or repeated pixel.
- Async reset asserted at (700,300) between clock edges -> outputs go to reset values before the next edge. Release -> (0,0) with frame_start.
- Parameter override to a tiny mode (H: 4/1/2/1, V: 3/1/1/1) -> H_TOTAL=8, V_TOTAL=6. hsync active at hpos 5..6, vsync active on line 4. Frame period is 48 cycles.
